// File: rtl/exu_lsu_ctrl_if.sv
// exu_lsu_ctrl_if: ALU-stage request, data-bus and writeback signals of the load/store controller
interface exu_lsu_ctrl_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_mem_wen;
    logic        i_mem_ren;
    logic [31:0] i_mem_addr;
    logic [31:0] i_alu_res;
    logic [31:0] i_store_data;
    logic [2:0]  i_funct3;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_wb_valid;
    logic        o_wb_rd_wen;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_bus_err;

    modport slave (
        input  i_valid, i_mem_wen, i_mem_ren, i_mem_addr, i_alu_res, i_store_data,
        input  i_funct3, i_rd_wen, i_rd_addr, i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        output o_ready, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        output o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_data, o_misalign, o_bus_err
    );

    modport master (
        output i_valid, i_mem_wen, i_mem_ren, i_mem_addr, i_alu_res, i_store_data,
        output i_funct3, i_rd_wen, i_rd_addr, i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        input  o_ready, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        input  o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_data, o_misalign, o_bus_err
    );
endinterface

// File: rtl/exu_lsu_ctrl.sv
// exu_lsu_ctrl: load/store unit controller between the ALU stage, the data bus and register writeback
module exu_lsu_ctrl #(
    parameter logic [7:0] WAIT_MAX = 8'd255
) (
    input logic           clk,
    input logic           rst_n,
    exu_lsu_ctrl_if.slave lsu
);
    typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        rd_wen_q;
    logic [4:0]  rd_addr_q;
    logic [1:0]  size;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        timeout;

    assign lsu.o_ready = (state == IDLE);

    // Access decode at accept time and lane extraction of returning load data
    always_comb begin
        size      = lsu.i_funct3[1:0];
        misalign  = (size == 2'b01 && lsu.i_mem_addr[0]) || (size[1] && lsu.i_mem_addr[1:0] != 2'b00);
        be        = size == 2'b00 ? 4'b0001 << lsu.i_mem_addr[1:0] :
                    size == 2'b01 ? 4'b0011 << lsu.i_mem_addr[1:0] : 4'b1111;
        wdata     = size == 2'b00 ? {4{lsu.i_store_data[7:0]}} :
                    size == 2'b01 ? {2{lsu.i_store_data[15:0]}} : lsu.i_store_data;
        shifted   = lsu.i_bus_rdata >> {off_q, 3'b000};
        load_data = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]} :
                    funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]} :
                    lsu.i_bus_rdata;
        timeout   = (cnt == WAIT_MAX - 8'd1);
    end

    // Controller FSM with registered bus and writeback outputs; wb_valid and flags pulse for one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            funct3_q         <= '0;
            off_q            <= '0;
            rd_wen_q         <= 1'b0;
            rd_addr_q        <= '0;
            lsu.o_bus_req    <= 1'b0;
            lsu.o_bus_we     <= 1'b0;
            lsu.o_bus_addr   <= '0;
            lsu.o_bus_wdata  <= '0;
            lsu.o_bus_be     <= '0;
            lsu.o_wb_valid   <= 1'b0;
            lsu.o_wb_rd_wen  <= 1'b0;
            lsu.o_wb_rd_addr <= '0;
            lsu.o_wb_data    <= '0;
            lsu.o_misalign   <= 1'b0;
            lsu.o_bus_err    <= 1'b0;
        end else begin
            lsu.o_wb_valid <= 1'b0;
            lsu.o_misalign <= 1'b0;
            lsu.o_bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu.i_valid) begin
                        funct3_q         <= lsu.i_funct3;
                        off_q            <= lsu.i_mem_addr[1:0];
                        rd_wen_q         <= lsu.i_rd_wen;
                        rd_addr_q        <= lsu.i_rd_addr;
                        lsu.o_wb_rd_addr <= lsu.i_rd_addr;
                        cnt              <= '0;
                        if (!lsu.i_mem_wen && !lsu.i_mem_ren) begin
                            lsu.o_wb_valid  <= 1'b1;
                            lsu.o_wb_rd_wen <= lsu.i_rd_wen;
                            lsu.o_wb_data   <= lsu.i_alu_res;
                        end else if (lsu.i_mem_wen && lsu.i_mem_ren) begin
                            lsu.o_wb_valid  <= 1'b1;
                            lsu.o_wb_rd_wen <= 1'b0;
                            lsu.o_bus_err   <= 1'b1;
                        end else if (misalign) begin
                            lsu.o_wb_valid  <= 1'b1;
                            lsu.o_wb_rd_wen <= 1'b0;
                            lsu.o_misalign  <= 1'b1;
                        end else begin
                            state           <= BUS_REQ;
                            lsu.o_bus_req   <= 1'b1;
                            lsu.o_bus_we    <= lsu.i_mem_wen;
                            lsu.o_bus_addr  <= {lsu.i_mem_addr[31:2], 2'b00};
                            lsu.o_bus_be    <= be;
                            lsu.o_bus_wdata <= wdata;
                        end
                    end
                end
                BUS_REQ: begin
                    if (lsu.i_bus_gnt) begin
                        lsu.o_bus_req <= 1'b0;
                        cnt           <= '0;
                        if (lsu.o_bus_we) begin
                            state           <= IDLE;
                            lsu.o_wb_valid  <= 1'b1;
                            lsu.o_wb_rd_wen <= 1'b0;
                        end else begin
                            state <= BUS_WAIT;
                        end
                    end else if (timeout) begin
                        state           <= IDLE;
                        lsu.o_bus_req   <= 1'b0;
                        lsu.o_wb_valid  <= 1'b1;
                        lsu.o_wb_rd_wen <= 1'b0;
                        lsu.o_bus_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BUS_WAIT: begin
                    if (lsu.i_bus_rvalid) begin
                        state           <= IDLE;
                        lsu.o_wb_valid  <= 1'b1;
                        lsu.o_wb_rd_wen <= rd_wen_q;
                        lsu.o_wb_rd_addr <= rd_addr_q;
                        lsu.o_wb_data   <= load_data;
                    end else if (timeout) begin
                        state           <= IDLE;
                        lsu.o_wb_valid  <= 1'b1;
                        lsu.o_wb_rd_wen <= 1'b0;
                        lsu.o_bus_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// tb_exu_lsu_ctrl: directed vector table, hand sequences and randomized ops against a reference model
module tb_exu_lsu_ctrl;
    localparam int WMAX = 4;

    typedef struct {
        logic        wen, ren;
        logic [31:0] addr, alu, sd, rdata;
        logic [2:0]  f3;
        logic        rd_wen;
        logic [4:0]  rd;
        int          gnt_dly, rv_dly;
        int          e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata, e_data;
        logic        e_chk_data, e_rd_wen, e_mis, e_err;
    } vec_t;

    logic clk = 0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail = 0;

    exu_lsu_ctrl_if bus();

    exu_lsu_ctrl #(.WAIT_MAX(8'(WMAX))) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic ren, input logic [31:0] addr,
                                input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                                input logic [2:0] f3, input logic rd_wen, input logic [4:0] rd,
                                input int gnt_dly, input int rv_dly);
        vec_t v;
        v = '{default: '0};
        v.wen = wen; v.ren = ren; v.addr = addr; v.alu = alu; v.sd = sd; v.rdata = rdata;
        v.f3 = f3; v.rd_wen = rd_wen; v.rd = rd; v.gnt_dly = gnt_dly; v.rv_dly = rv_dly;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input int req, input logic [31:0] a, input logic [3:0] be,
                                input logic we, input logic [31:0] wd, input logic [31:0] d,
                                input logic chkd, input logic rdw, input logic mis, input logic err);
        vec_t r;
        r = v;
        r.e_req = req; r.e_addr = a; r.e_be = be; r.e_we = we; r.e_wdata = wd; r.e_data = d;
        r.e_chk_data = chkd; r.e_rd_wen = rdw; r.e_mis = mis; r.e_err = err;
        return r;
    endfunction

    // Reference: access size in bytes, alignment by modulo, lanes by arithmetic shifts and masks
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          n, off;
        logic [63:0] mask, val;
        r = v;
        n = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(v.addr % 4);
        r.e_req = 0; r.e_chk_data = 0; r.e_rd_wen = 0; r.e_mis = 0; r.e_err = 0;
        r.e_addr = v.addr - 32'(off);
        r.e_be = 4'(((1 << n) - 1) << off);
        r.e_we = v.wen;
        for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.sd[8*(i % n) +: 8];
        if (!v.wen && !v.ren) begin
            r.e_data = v.alu; r.e_chk_data = 1; r.e_rd_wen = v.rd_wen;
        end else if (v.wen && v.ren) begin
            r.e_err = 1;
        end else if (v.addr % n != 0) begin
            r.e_mis = 1;
        end else if (v.gnt_dly >= WMAX) begin
            r.e_req = WMAX; r.e_err = 1;
        end else begin
            r.e_req = v.gnt_dly + 1;
            if (v.ren) begin
                if (v.rv_dly >= WMAX) r.e_err = 1;
                else begin
                    mask = (64'd1 << (8 * n)) - 64'd1;
                    val = (64'(v.rdata) >> (8 * off)) & mask;
                    if (!v.f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
                    r.e_data = val[31:0]; r.e_chk_data = 1; r.e_rd_wen = v.rd_wen;
                end
            end
        end
        return r;
    endfunction

    task automatic clear_inputs();
        bus.i_valid = 0; bus.i_mem_wen = 0; bus.i_mem_ren = 0; bus.i_mem_addr = 0;
        bus.i_alu_res = 0; bus.i_store_data = 0; bus.i_funct3 = 0; bus.i_rd_wen = 0;
        bus.i_rd_addr = 0; bus.i_bus_gnt = 0; bus.i_bus_rvalid = 0; bus.i_bus_rdata = 0;
    endtask

    task automatic drive(input vec_t v);
        bus.i_valid = 1; bus.i_mem_wen = v.wen; bus.i_mem_ren = v.ren; bus.i_mem_addr = v.addr;
        bus.i_alu_res = v.alu; bus.i_store_data = v.sd; bus.i_funct3 = v.f3;
        bus.i_rd_wen = v.rd_wen; bus.i_rd_addr = v.rd;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        logic        got, granted, hold_ok, gnt_now, w_we, w_rdw, w_mis, w_err;
        logic [31:0] a0, d0, w_data;
        logic [3:0]  b0;
        logic [4:0]  w_rd;
        int          req, w;
        got = 0; granted = 0; hold_ok = 1; req = 0; w = 0;
        a0 = 'x; d0 = 'x; b0 = 'x; w_we = 'x; w_data = 'x; w_rdw = 'x; w_rd = 'x; w_mis = 'x; w_err = 'x;
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        drive(v);
        step();
        bus.i_valid = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (bus.o_wb_valid) begin
                got = 1; w_data = bus.o_wb_data; w_rdw = bus.o_wb_rd_wen; w_rd = bus.o_wb_rd_addr;
                w_mis = bus.o_misalign; w_err = bus.o_bus_err;
            end else begin
                gnt_now = 0;
                bus.i_bus_gnt = 0; bus.i_bus_rvalid = 0; bus.i_bus_rdata = $urandom;
                if (bus.o_bus_req) begin
                    if (req == 0) begin
                        a0 = bus.o_bus_addr; b0 = bus.o_bus_be; d0 = bus.o_bus_wdata; w_we = bus.o_bus_we;
                    end else if (a0 !== bus.o_bus_addr || b0 !== bus.o_bus_be ||
                                 d0 !== bus.o_bus_wdata || w_we !== bus.o_bus_we) begin
                        hold_ok = 0;
                    end
                    gnt_now = (req == v.gnt_dly);
                    req++;
                    bus.i_bus_gnt = gnt_now;
                    bus.i_bus_rvalid = 1'($urandom_range(0, 1));
                end else if (granted && v.ren) begin
                    bus.i_bus_rvalid = (w == v.rv_dly);
                    if (w == v.rv_dly) bus.i_bus_rdata = v.rdata;
                    w++;
                end
                step();
                if (gnt_now) granted = 1;
            end
        end
        bus.i_bus_gnt = 0; bus.i_bus_rvalid = 0;
        chk({tag, "_wb_seen"}, 32'(got), 32'd1);
        chk({tag, "_req_cycles"}, 32'(req), 32'(v.e_req));
        chk({tag, "_misalign"}, 32'(w_mis), 32'(v.e_mis));
        chk({tag, "_bus_err"}, 32'(w_err), 32'(v.e_err));
        chk({tag, "_rd_wen"}, 32'(w_rdw), 32'(v.e_rd_wen));
        if (v.e_rd_wen) chk({tag, "_rd_addr"}, 32'(w_rd), 32'(v.rd));
        if (v.e_chk_data) chk({tag, "_wb_data"}, w_data, v.e_data);
        if (v.e_req > 0) begin
            chk({tag, "_bus_addr"}, a0, v.e_addr);
            chk({tag, "_bus_be"}, 32'(b0), 32'(v.e_be));
            chk({tag, "_bus_we"}, 32'(w_we), 32'(v.e_we));
            chk({tag, "_bus_hold"}, 32'(hold_ok), 32'd1);
            if (v.e_we) chk({tag, "_bus_wdata"}, d0, v.e_wdata);
        end
        step();
        chk({tag, "_single_pulse"}, 32'(bus.o_wb_valid), 32'd0);
    endtask

    vec_t tbl[13];
    vec_t rv;
    logic [2:0] f3s[5];

    initial begin
        clear_inputs();
        rst_n = 0;
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

        tbl[0]  = ex(mk(0, 0, 32'h0, 32'h1234, 32'h0, 32'h0, 3'b000, 1, 5'd5, 0, 0),
                     0, 0, 0, 0, 0, 32'h00001234, 1, 1, 0, 0);
        tbl[1]  = ex(mk(1, 0, 32'h1003, 32'h0, 32'hAABBCCDD, 32'h0, 3'b000, 0, 5'd0, 2, 0),
                     3, 32'h1000, 4'b1000, 1, 32'hDDDDDDDD, 0, 0, 0, 0, 0);
        tbl[2]  = ex(mk(0, 1, 32'h2002, 32'h0, 32'h0, 32'h0080FF00, 3'b000, 1, 5'd7, 0, 0),
                     1, 32'h2000, 4'b0100, 0, 0, 32'hFFFFFF80, 1, 1, 0, 0);
        tbl[3]  = ex(mk(0, 1, 32'h2002, 32'h0, 32'h0, 32'h0080FF00, 3'b100, 1, 5'd7, 1, 2),
                     2, 32'h2000, 4'b0100, 0, 0, 32'h00000080, 1, 1, 0, 0);
        tbl[4]  = ex(mk(0, 1, 32'h2002, 32'h0, 32'h0, 32'h0, 3'b010, 1, 5'd3, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[5]  = ex(mk(0, 1, 32'h2002, 32'h0, 32'h0, 32'h80011234, 3'b001, 1, 5'd9, 0, 1),
                     1, 32'h2000, 4'b1100, 0, 0, 32'hFFFF8001, 1, 1, 0, 0);
        tbl[6]  = ex(mk(0, 1, 32'h2000, 32'h0, 32'h0, 32'h0, 3'b010, 1, 5'd4, 1000, 0),
                     WMAX, 32'h2000, 4'b1111, 0, 0, 0, 0, 0, 0, 1);
        tbl[7]  = ex(mk(1, 1, 32'h2000, 32'h0, 32'h0, 32'h0, 3'b010, 1, 5'd4, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[8]  = ex(mk(1, 0, 32'h3002, 32'h0, 32'h11223344, 32'h0, 3'b001, 1, 5'd1, 0, 0),
                     1, 32'h3000, 4'b1100, 1, 32'h33443344, 0, 0, 0, 0, 0);
        tbl[9]  = ex(mk(1, 0, 32'h4000, 32'h0, 32'hCAFEF00D, 32'h0, 3'b010, 0, 5'd0, 3, 0),
                     4, 32'h4000, 4'b1111, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0);
        tbl[10] = ex(mk(0, 1, 32'h2000, 32'h0, 32'h0, 32'h1234ABCD, 3'b101, 1, 5'd31, 0, 0),
                     1, 32'h2000, 4'b0011, 0, 0, 32'h0000ABCD, 1, 1, 0, 0);
        tbl[11] = ex(mk(1, 0, 32'h3001, 32'h0, 32'h0, 32'h0, 3'b001, 0, 5'd0, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = ex(mk(0, 1, 32'h5004, 32'h0, 32'h0, 32'h0, 3'b010, 1, 5'd2, 0, 1000),
                     1, 32'h5004, 4'b1111, 0, 0, 0, 0, 0, 0, 1);

        step();
        step();
        chk("reset_ready", 32'(bus.o_ready), 32'd1);
        chk("reset_bus_req", 32'(bus.o_bus_req), 32'd0);
        chk("reset_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        chk("reset_flags", {30'd0, bus.o_misalign, bus.o_bus_err}, 32'd0);
        chk("reset_bus_be", 32'(bus.o_bus_be), 32'd0);
        rst_n = 1;
        step();

        for (int i = 0; i < 13; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        for (int k = 0; k < 3; k++) begin
            drive(mk(0, 0, 0, 32'h100 + 32'(k), 0, 0, 3'b000, 1, 5'(5 + k), 0, 0));
            step();
            chk($sformatf("b2b%0d_valid", k), 32'(bus.o_wb_valid), 32'd1);
            chk($sformatf("b2b%0d_data", k), bus.o_wb_data, 32'h100 + 32'(k));
            chk($sformatf("b2b%0d_rd", k), 32'(bus.o_wb_rd_addr), 32'(5 + k));
        end
        bus.i_valid = 0;
        step();
        chk("b2b_end", 32'(bus.o_wb_valid), 32'd0);

        drive(mk(0, 1, 32'h5000, 0, 0, 0, 3'b010, 1, 5'd6, 0, 0));
        step();
        bus.i_valid = 0;
        chk("rst_mid_req", 32'(bus.o_bus_req), 32'd1);
        bus.i_bus_gnt = 1;
        step();
        bus.i_bus_gnt = 0;
        chk("rst_mid_wait", 32'(bus.o_ready), 32'd0);
        rst_n = 0;
        step();
        rst_n = 1;
        bus.i_bus_rvalid = 1;
        bus.i_bus_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_mid_nowb%0d", k), 32'(bus.o_wb_valid), 32'd0);
            chk($sformatf("rst_mid_ready%0d", k), 32'(bus.o_ready), 32'd1);
            step();
        end
        bus.i_bus_rvalid = 0;

        for (int i = 0; i < 150; i++) begin
            rv = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                    $urandom, $urandom, $urandom, f3s[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) begin
                rv.wen = 0; rv.ren = 0;
            end else if (rv.wen && rv.ren && $urandom_range(0, 3) != 0) begin
                rv.wen = 0;
            end
            do_op(model(rv), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exu_lsu_ctrl.md
EXU_LSU_CTRL -- requirements
Module: exu_lsu_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, 8'd255, bus cycles waited in BUS_REQ or BUS_WAIT before a bus error is raised.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_valid  in  1  upstream ALU result valid.
REQ-005 o_ready  out  1  block can accept; 1 only in IDLE.
REQ-006 i_mem_wen / i_mem_ren  in  1 each  store / load request from the ALU stage.
REQ-007 i_mem_addr  in  32  effective byte address.
REQ-008 i_alu_res  in  32  ALU result, passed through for non-memory ops.
REQ-009 i_store_data  in  32  rs2 value for stores.
REQ-010 i_funct3  in  3  size and sign: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
REQ-011 i_rd_wen, i_rd_addr  in  1, 5  destination register.
REQ-012 o_bus_req, o_bus_we  out  1 each  bus request and write strobe.
REQ-013 o_bus_addr, o_bus_wdata  out  32 each  word-aligned address and write data.
REQ-014 o_bus_be  out  4  byte enables.
REQ-015 i_bus_gnt, i_bus_rvalid  in  1 each  grant and read-data valid.
REQ-016 i_bus_rdata  in  32  read data.
REQ-017 o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_data  out  1, 1, 5, 32  writeback to the register file.
REQ-018 o_misalign, o_bus_err  out  1 each  exception flags; valid only with o_wb_valid.

Function
REQ-019 FSM states SHALL be IDLE, BUS_REQ and BUS_WAIT; o_ready = (state==IDLE).
REQ-020 Accept SHALL occur on i_valid & o_ready; all inputs are captured into internal registers at accept.
REQ-021 Non-memory op (no mem_wen, no mem_ren): next cycle o_wb_valid=1, o_wb_data=i_alu_res, rd_wen/rd_addr passed through; FSM stays in IDLE, so back-to-back accept is possible every cycle.
REQ-022 Misalign: half with addr[0]=1, or word with addr[1:0]!=0; next cycle o_wb_valid=1, o_misalign=1, o_wb_rd_wen=0; no bus request is issued.
REQ-023 Both mem_wen and mem_ren set: next cycle o_wb_valid=1, o_bus_err=1, o_wb_rd_wen=0; no bus request is issued.
REQ-024 Aligned memory op: FSM goes IDLE->BUS_REQ; o_bus_req=1 with addr/we/be/wdata held stable until i_bus_gnt is sampled high.
REQ-025 o_bus_addr SHALL be {addr[31:2],2'b00}.
REQ-026 Store byte: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
REQ-027 Store half: wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0].
REQ-028 Store word: wdata=rs2, be=4'b1111.
REQ-029 Load: be SHALL follow the same rules as stores; we=0.
REQ-030 Store: on gnt the FSM returns to IDLE; next cycle o_wb_valid=1 with o_wb_rd_wen=0.
REQ-031 Load: on gnt, BUS_REQ->BUS_WAIT; i_bus_rvalid is sampled only in BUS_WAIT and ignored elsewhere.
REQ-032 On rvalid: select the byte or half at addr[1:0]; sign-extend for 000/001, zero-extend for 100/101; next cycle o_wb_valid=1 with o_wb_data set to the result and captured rd_wen/rd_addr; FSM -> IDLE.
REQ-033 Wait counter: cleared on entry to BUS_REQ and on the BUS_REQ->BUS_WAIT transition; increments every cycle in those states.
REQ-034 Counter reaching WAIT_MAX: o_bus_req drops, FSM -> IDLE, next cycle o_wb_valid=1, o_bus_err=1, o_wb_rd_wen=0.
REQ-035 o_wb_valid SHALL be a single-cycle pulse per accepted op; exactly one pulse per accept, in order.
REQ-036 o_bus_req SHALL never assert outside BUS_REQ.

Reset
REQ-037 On clk edge with rst_n=0: state=IDLE and the wait counter is cleared.
REQ-038 On clk edge with rst_n=0: all outputs are 0 except o_ready=1 (o_ready is 1 during and after reset).
REQ-039 Reset mid-transaction (BUS_REQ/BUS_WAIT) SHALL abandon the op with no writeback pulse; a late rvalid after reset is ignored.

Verification
REQ-040 ADD result 0x1234 to rd=5, non-mem -> next cycle wb_valid=1, rd_addr=5, data=0x00001234; three back-to-back ops give three consecutive pulses.
REQ-041 SB rs2=0xAABBCCDD at 0x1003, gnt after 2 cycles -> bus_addr=0x1000, be=1000, wdata=0xDDDDDDDD held for 3 cycles; then wb_valid with rd_wen=0.
REQ-042 LB at 0x2002, rdata=0x0080FF00 -> wb_data=0xFFFFFF80; the same with LBU gives 0x00000080.
REQ-043 LW at 0x2002 -> misalign=1 with wb_valid next cycle and no bus_req; LH at 0x2002 -> be=1100, normal completion.
REQ-044 LW with gnt never asserted, WAIT_MAX=4 -> bus_req drops after 4 cycles, bus_err=1, rd_wen=0.
REQ-045 Assert rst_n=0 in BUS_WAIT, then rvalid=1 -> no wb_valid, o_ready=1, state IDLE.
